// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencer for the 5-stage core.
// Detects decode hazards, applies branch flushes and cache freezes,
// drives every pipeline-register enable/flush and runs the HLT drain FSM.
module hazard_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             d_valid,
    input  logic [3:0]       d_rs,
    input  logic [3:0]       d_rt,
    input  logic             d_uses_rs,
    input  logic             d_uses_rt,
    input  logic             d_branch,
    input  logic             d_branch_reg,
    input  logic             d_branch_taken,
    input  logic             d_halt,
    input  logic [3:0]       x_rd,
    input  logic             x_reg_write_en,
    input  logic             x_mem_read_en,
    input  logic             x_writes_flags,
    input  logic [3:0]       m_rd,
    input  logic             m_reg_write_en,
    input  logic             m_mem_read_en,
    input  logic             icache_busy,
    input  logic             dcache_busy,
    output logic             pc_wen,
    output logic             if_id_wen,
    output logic             if_id_flush,
    output logic             id_ex_wen,
    output logic             id_ex_flush,
    output logic             ex_mem_wen,
    output logic             mem_wb_wen,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count
);

    // Drain counter wide enough to hold DRAIN_CYCLES (at least one bit).
    localparam int DW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [DW-1:0] drain_cnt_r;
    logic [DW-1:0] drain_cnt_nxt_s;
    logic          hz_s;
    logic          count_en_s;

    // A source register collides with a destination only when rd is not r0.
    function automatic logic reg_match(input logic [3:0] src, input logic [3:0] rd);
        return (rd != 4'd0) && (src == rd);
    endfunction

    // Decode hazard: load-use, flags not yet produced, or BR target not ready.
    always_comb begin
        hz_s = 1'b0;
        if (d_valid) begin
            hz_s = (x_mem_read_en & x_reg_write_en &
                    ((d_uses_rs & reg_match(d_rs, x_rd)) |
                     (d_uses_rt & reg_match(d_rt, x_rd))))
                 | (d_branch & x_writes_flags)
                 | (d_branch_reg &
                    ((x_reg_write_en & reg_match(d_rs, x_rd)) |
                     (m_mem_read_en & m_reg_write_en & reg_match(d_rs, m_rd))));
        end else begin
            hz_s = 1'b0;
        end
    end

    // Stage enables, flushes and next-state selection by state and priority.
    always_comb begin
        pc_wen          = 1'b1;
        if_id_wen       = 1'b1;
        if_id_flush     = 1'b0;
        id_ex_wen       = 1'b1;
        id_ex_flush     = 1'b0;
        ex_mem_wen      = 1'b1;
        mem_wb_wen      = 1'b1;
        halted          = 1'b0;
        state_nxt_s     = state_r;
        drain_cnt_nxt_s = drain_cnt_r;
        case (state_r)
            ST_RUN: begin
                if (dcache_busy) begin
                    pc_wen     = 1'b0;
                    if_id_wen  = 1'b0;
                    id_ex_wen  = 1'b0;
                    ex_mem_wen = 1'b0;
                    mem_wb_wen = 1'b0;
                end else if (hz_s) begin
                    pc_wen      = 1'b0;
                    if_id_wen   = 1'b0;
                    id_ex_flush = 1'b1;
                end else if (d_valid && d_halt) begin
                    pc_wen          = 1'b0;
                    if_id_flush     = 1'b1;
                    state_nxt_s     = ST_DRAIN;
                    drain_cnt_nxt_s = DW'(DRAIN_CYCLES);
                end else if (d_valid && d_branch && d_branch_taken) begin
                    // Branch beats an outstanding icache miss; fetch cancels it.
                    pc_wen      = 1'b1;
                    if_id_flush = 1'b1;
                end else if (icache_busy) begin
                    pc_wen      = 1'b0;
                    if_id_flush = 1'b1;
                end else begin
                    pc_wen = 1'b1;
                end
            end
            ST_DRAIN: begin
                pc_wen      = 1'b0;
                if_id_wen   = 1'b0;
                id_ex_flush = 1'b1;
                ex_mem_wen  = ~dcache_busy;
                mem_wb_wen  = ~dcache_busy;
                if (!dcache_busy) begin
                    if (drain_cnt_r <= DW'(1)) begin
                        drain_cnt_nxt_s = '0;
                        state_nxt_s     = ST_HALTED;
                    end else begin
                        drain_cnt_nxt_s = drain_cnt_r - DW'(1);
                    end
                end else begin
                    drain_cnt_nxt_s = drain_cnt_r;
                end
            end
            ST_HALTED: begin
                pc_wen     = 1'b0;
                if_id_wen  = 1'b0;
                id_ex_wen  = 1'b0;
                ex_mem_wen = 1'b0;
                mem_wb_wen = 1'b0;
                halted     = 1'b1;
            end
            default: begin
                // Unreachable encoding: freeze the pipe and recover to RUN.
                pc_wen      = 1'b0;
                if_id_wen   = 1'b0;
                id_ex_wen   = 1'b0;
                ex_mem_wen  = 1'b0;
                mem_wb_wen  = 1'b0;
                state_nxt_s = ST_RUN;
            end
        endcase
    end

    // Stall cycles are counted only while the core is live (RUN or DRAIN).
    always_comb begin
        if ((state_r == ST_RUN) || (state_r == ST_DRAIN)) begin
            count_en_s = ~pc_wen;
        end else begin
            count_en_s = 1'b0;
        end
    end

    // State, drain counter and saturating stall counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_RUN;
            drain_cnt_r <= '0;
            stall_count <= '0;
        end else begin
            state_r     <= state_nxt_s;
            drain_cnt_r <= drain_cnt_nxt_s;
            if (count_en_s && (stall_count != CNT_MAX)) begin
                stall_count <= stall_count + CNT_W'(1);
            end else begin
                stall_count <= stall_count;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: expected control vectors are queued
// when each stimulus cycle is driven and popped when the outputs are sampled.
module tb_hazard_ctrl;

    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic d_valid, d_uses_rs, d_uses_rt, d_branch, d_branch_reg, d_branch_taken, d_halt;
    logic [3:0] d_rs, d_rt, x_rd, m_rd;
    logic x_reg_write_en, x_mem_read_en, x_writes_flags;
    logic m_reg_write_en, m_mem_read_en, icache_busy, dcache_busy;
    logic pc_wen, if_id_wen, if_id_flush, id_ex_wen, id_ex_flush, ex_mem_wen, mem_wb_wen;
    logic halted;
    logic [CNT_W-1:0] stall_count;

    hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
        .d_uses_rs(d_uses_rs), .d_uses_rt(d_uses_rt),
        .d_branch(d_branch), .d_branch_reg(d_branch_reg),
        .d_branch_taken(d_branch_taken), .d_halt(d_halt),
        .x_rd(x_rd), .x_reg_write_en(x_reg_write_en),
        .x_mem_read_en(x_mem_read_en), .x_writes_flags(x_writes_flags),
        .m_rd(m_rd), .m_reg_write_en(m_reg_write_en), .m_mem_read_en(m_mem_read_en),
        .icache_busy(icache_busy), .dcache_busy(dcache_busy),
        .pc_wen(pc_wen), .if_id_wen(if_id_wen), .if_id_flush(if_id_flush),
        .id_ex_wen(id_ex_wen), .id_ex_flush(id_ex_flush),
        .ex_mem_wen(ex_mem_wen), .mem_wb_wen(mem_wb_wen),
        .halted(halted), .stall_count(stall_count)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Control vector order: {pc_wen, if_id_wen, if_id_flush, id_ex_wen, id_ex_flush, ex_mem_wen, mem_wb_wen}
    localparam logic [6:0] C_DEF  = 7'b1101011;
    localparam logic [6:0] C_HZ   = 7'b0001111;
    localparam logic [6:0] C_DC   = 7'b0000000;
    localparam logic [6:0] C_HLT  = 7'b0111011;
    localparam logic [6:0] C_BR   = 7'b1111011;
    localparam logic [6:0] C_IC   = 7'b0111011;
    localparam logic [6:0] C_DR   = 7'b0001111;
    localparam logic [6:0] C_DRB  = 7'b0001100;
    localparam logic [6:0] C_HALT = 7'b0000000;

    typedef struct {
        string            tag;
        logic [6:0]       ctl;
        logic             hlt;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    logic             halted_exp = 1'b0;
    logic [CNT_W-1:0] cnt_exp = '0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic clr();
        d_valid = 1'b0; d_rs = 4'd0; d_rt = 4'd0; d_uses_rs = 1'b0; d_uses_rt = 1'b0;
        d_branch = 1'b0; d_branch_reg = 1'b0; d_branch_taken = 1'b0; d_halt = 1'b0;
        x_rd = 4'd0; x_reg_write_en = 1'b0; x_mem_read_en = 1'b0; x_writes_flags = 1'b0;
        m_rd = 4'd0; m_reg_write_en = 1'b0; m_mem_read_en = 1'b0;
        icache_busy = 1'b0; dcache_busy = 1'b0;
    endtask

    // One cycle: inputs already driven; queue expectation, sample, compare, advance.
    task automatic step(input string tag, input logic [6:0] ctl);
        exp_t e;
        exp_q.push_back('{tag, ctl, halted_exp, cnt_exp});
        #2;
        e = exp_q.pop_front();
        check_val({e.tag, "_ctl"}, {25'd0, pc_wen, if_id_wen, if_id_flush, id_ex_wen,
                                    id_ex_flush, ex_mem_wen, mem_wb_wen}, {25'd0, e.ctl});
        check_val({e.tag, "_halted"}, {31'd0, halted}, {31'd0, e.hlt});
        check_val({e.tag, "_cnt"}, {16'd0, stall_count}, {16'd0, e.cnt});
        @(posedge clk);
        if (!halted_exp && !ctl[6] && (cnt_exp != {CNT_W{1'b1}})) cnt_exp = cnt_exp + 16'd1;
        @(negedge clk);
    endtask

    task automatic do_reset();
        clr();
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        halted_exp = 1'b0;
        cnt_exp = '0;
    endtask

    initial begin
        clr();
        @(negedge clk);
        do_reset();
        step("reset_idle", C_DEF);

        // Load-use on rs, then load moves to MEM and the stall clears.
        clr(); d_valid = 1'b1; d_uses_rs = 1'b1; d_rs = 4'd3;
        x_rd = 4'd3; x_mem_read_en = 1'b1; x_reg_write_en = 1'b1;
        step("lu_rs", C_HZ);
        x_rd = 4'd0; x_mem_read_en = 1'b0; x_reg_write_en = 1'b0;
        m_rd = 4'd3; m_mem_read_en = 1'b1; m_reg_write_en = 1'b1;
        step("lu_rs_next", C_DEF);

        // r0 never hazards.
        clr(); d_valid = 1'b1; d_uses_rs = 1'b1; d_rs = 4'd0;
        x_rd = 4'd0; x_mem_read_en = 1'b1; x_reg_write_en = 1'b1;
        step("lu_r0", C_DEF);

        // Load-use on rt, and the same registers without the rt read.
        clr(); d_valid = 1'b1; d_uses_rt = 1'b1; d_rt = 4'd7;
        x_rd = 4'd7; x_mem_read_en = 1'b1; x_reg_write_en = 1'b1;
        step("lu_rt", C_HZ);
        d_uses_rt = 1'b0;
        step("lu_rt_unused", C_DEF);

        // Bubble in ID cannot hazard.
        d_valid = 1'b0; d_uses_rt = 1'b1;
        step("bubble", C_DEF);

        // Flag hazard overrides a taken branch; next cycle branch is taken.
        clr(); d_valid = 1'b1; d_branch = 1'b1; d_branch_taken = 1'b1; x_writes_flags = 1'b1;
        step("flag_hz", C_HZ);
        x_writes_flags = 1'b0;
        step("branch_taken", C_BR);

        // BR register hazards: MEM load, MEM non-load, EX register write.
        clr(); d_valid = 1'b1; d_branch = 1'b1; d_branch_reg = 1'b1; d_rs = 4'd5;
        m_rd = 4'd5; m_mem_read_en = 1'b1; m_reg_write_en = 1'b1;
        step("br_mem_load", C_HZ);
        m_mem_read_en = 1'b0;
        step("br_mem_alu", C_DEF);
        m_reg_write_en = 1'b0; x_rd = 4'd5; x_reg_write_en = 1'b1;
        step("br_ex_write", C_HZ);

        // dcache freeze dominates a hazard.
        dcache_busy = 1'b1;
        step("dcache_over_hz", C_DC);

        // icache miss alone, then together with a taken branch.
        clr(); icache_busy = 1'b1;
        step("icache", C_IC);
        d_valid = 1'b1; d_branch = 1'b1; d_branch_taken = 1'b1;
        step("icache_branch", C_BR);

        // HLT behind a hazard: stall first, then accept, then drain.
        clr(); d_valid = 1'b1; d_halt = 1'b1; d_uses_rs = 1'b1; d_rs = 4'd2;
        x_rd = 4'd2; x_mem_read_en = 1'b1; x_reg_write_en = 1'b1;
        step("hlt_hz", C_HZ);
        x_mem_read_en = 1'b0; x_reg_write_en = 1'b0;
        step("hlt_accept_after_hz", C_HLT);
        clr();
        step("hlt_drain0", C_DR);

        // Full HLT drain with a 2-cycle dcache stall; halted after 6 cycles.
        do_reset();
        d_valid = 1'b1; d_halt = 1'b1;
        step("hlt_accept", C_HLT);
        clr(); icache_busy = 1'b1; d_valid = 1'b1; d_branch = 1'b1; d_branch_taken = 1'b1;
        step("drain1", C_DR);
        step("drain2", C_DR);
        dcache_busy = 1'b1;
        step("drain_busy1", C_DRB);
        step("drain_busy2", C_DRB);
        dcache_busy = 1'b0;
        step("drain3", C_DR);
        halted_exp = 1'b1;
        step("halted1", C_HALT);
        check_val("halted_cnt6", {16'd0, stall_count}, 32'd6);
        clr(); d_valid = 1'b1;
        step("halted2", C_HALT);

        // Reset from HALTED returns to RUN with a cleared counter.
        do_reset();
        step("post_halt_reset", C_DEF);

        // Saturation: hold the dcache freeze long enough to wrap a 16-bit counter.
        dcache_busy = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            @(posedge clk);
        end
        @(negedge clk);
        cnt_exp = {CNT_W{1'b1}};
        step("saturate", C_DC);
        step("saturate_hold", C_DC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Central pipeline sequencer for the 5-stage core: IF, ID, EX, MEM, WB.
- Detects load-use, flag and branch-register hazards against the instruction in decode.
- Applies taken-branch flushes and cache-miss freezes.
- Drives every pipeline-register write enable and flush.
- Runs the HLT drain state machine that raises `halted` once the pipeline is empty.

Parameters:
DRAIN_CYCLES, 3, cycles after HLT leaves ID until WB has retired it
CNT_W, 16, width of saturating stall-cycle performance counter

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  reset, synchronous, active-low
d_valid  in  1  ID holds a real instruction (0 = bubble)
d_rs  in  4  ID source register 1 (rs; BR target register)
d_rt  in  4  ID source register 2
d_uses_rs  in  1  ID instruction reads d_rs
d_uses_rt  in  1  ID instruction reads d_rt
d_branch  in  1  ID is B or BR
d_branch_reg  in  1  ID is BR (target read from d_rs in ID)
d_branch_taken  in  1  ID branch condition met with current flags
d_halt  in  1  ID is HLT
x_rd  in  4  EX destination register
x_reg_write_en  in  1  EX writes register file
x_mem_read_en  in  1  EX is a load
x_writes_flags  in  1  EX updates NZV (ADD/SUB/XOR/SLL/SRA/ROR)
m_rd  in  4  MEM destination register
m_reg_write_en  in  1  MEM writes register file
m_mem_read_en  in  1  MEM is a load
icache_busy  in  1  instruction fetch miss in progress
dcache_busy  in  1  data access miss in progress
pc_wen  out  1  PC register load
if_id_wen  out  1  IF/ID write
if_id_flush  out  1  IF/ID loads NOP (dominates if_id_wen)
id_ex_wen  out  1  ID/EX write
id_ex_flush  out  1  ID/EX loads bubble (dominates id_ex_wen)
ex_mem_wen  out  1  EX/MEM write
mem_wb_wen  out  1  MEM/WB write
halted  out  1  pipeline drained after HLT; sticky
stall_count  out  CNT_W  cycles with pc_wen=0 in RUN/DRAIN, saturating

Behaviour:
- Reset: rst_n=0 at a clk edge → state=RUN, drain counter=0, halted=0, stall_count=0. Reset mid-DRAIN or in HALTED also returns to RUN.
- Outputs are combinational from state and inputs. Default when nothing applies: all *_wen=1, all flushes=0.
- Register 0 never causes a hazard. All compares require rd!=0.
- `hz` is computed only when d_valid=1. It is 1 if any of the following holds:
  - Load-use: x_mem_read_en & x_reg_write_en & ((d_uses_rs & d_rs==x_rd) | (d_uses_rt & d_rt==x_rd)).
  - Flags: d_branch & x_writes_flags. Flags are not valid until EX completes.
  - BR-register: d_branch_reg & ((x_reg_write_en & d_rs==x_rd) | (m_mem_read_en & m_reg_write_en & d_rs==m_rd)).
- RUN, strict priority:
  1. dcache_busy: all *_wen=0, flushes=0, state holds.
  2. hz: pc_wen=0, if_id_wen=0, id_ex_flush=1; EX/MEM and MEM/WB advance. d_branch_taken and d_halt are ignored this cycle.
  3. d_valid & d_halt: pc_wen=0, if_id_flush=1, ID/EX takes HLT. Next state=DRAIN, counter loads DRAIN_CYCLES.
  4. d_valid & d_branch & d_branch_taken: pc_wen=1 (PC takes branch target), if_id_flush=1.
  5. icache_busy: pc_wen=0, if_id_flush=1; downstream stages advance.
- DRAIN:
  - pc_wen=0, if_id_wen=0, id_ex_flush=1, ex_mem_wen=mem_wb_wen=~dcache_busy.
  - Counter decrements only when dcache_busy=0.
  - On a decrement from 1 to 0, next state=HALTED.
  - Hazard, branch and icache inputs are ignored.
- HALTED: all *_wen=0, flushes=0, halted=1, until reset.
- stall_count increments when pc_wen=0 in RUN or DRAIN. It holds at 2^CNT_W-1 and does not count in HALTED.
- HLT in ID while a hazard is active: the stall is taken first; HLT is accepted on the first hazard-free cycle.
- Taken branch and icache_busy together: the branch wins (item 4). The fetch unit cancels the miss.

Test Plan:
- LW r3 in EX (x_rd=3, x_mem_read_en=1); ADD using d_rs=3 in ID → one cycle of pc_wen=0, if_id_wen=0, id_ex_flush=1; next cycle, with LW moved to MEM, all wen=1.
- x_rd=0 load with d_rs=0 → no stall; stall_count unchanged.
- SUB in EX (x_writes_flags=1), B in ID → 1-cycle stall. Next cycle d_branch_taken=1 → pc_wen=1, if_id_flush=1.
- BR with d_rs=5, MEM load m_rd=5 → stall. The same case with m_mem_read_en=0 → no stall.
- d_halt=1 with DRAIN_CYCLES=3, dcache_busy high for 2 cycles mid-drain → halted rises exactly 6 cycles after HLT acceptance; all wen=0 thereafter; stall_count=6.
- rst_n=0 in HALTED → next cycle halted=0, stall_count=0, all wen=1.
